// File: rtl/sine_pwm_pkg.sv
// Shared constants, stage widths and types for the multi-channel sine PWM.
package sine_pwm_pkg;

    localparam int N_CH_DEF   = 3;
    localparam int CNT_W_DEF  = 16;
    localparam int AW_DEF     = 8;
    localparam int DATA_W_DEF = 16;
    localparam int AMP_W      = 8;

    // Scale stage: signed sample (DATA_W+1) times zero-extended amp (AMP_W+1)
    localparam int SCL_W  = DATA_W_DEF + AMP_W + 2;
    // Period stage: DATA_W sample times (period+1), which needs CNT_W+1 bits
    localparam int PROD_W = DATA_W_DEF + CNT_W_DEF + 1;

    localparam logic [DATA_W_DEF-1:0] MIDSCALE = {1'b1, {(DATA_W_DEF-1){1'b0}}};

    // Configuration loaded by reset
    localparam int                RST_PERIOD    = 999;
    localparam logic [AW_DEF-1:0] RST_PHASE_INC = AW_DEF'(1);
    localparam logic [AMP_W-1:0]  RST_AMP       = AMP_W'(255);

    typedef struct packed {
        logic [CNT_W_DEF-1:0]               period;
        logic [AW_DEF-1:0]                  phase_inc;
        logic [AMP_W-1:0]                   amp;
        logic [N_CH_DEF-1:0][AW_DEF-1:0]    phase_off;
    } cfg_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_WAIT_WRAP
    } state_t;

endpackage

// File: rtl/sine_pwm_multi_lut.sv
// Synchronous single-port waveform ROM with one cycle of read latency.
// Contents are a linear ramp (entry a = a << (DATA_W-AW)); a sine table
// drops in by replacing the generate assignment below.
module sine_lut #(
    parameter int AW     = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic [AW-1:0]     addr,
    output logic [DATA_W-1:0] data
);

    logic [DATA_W-1:0] rom [2**AW];

    for (genvar i = 0; i < 2**AW; i++) begin : g_rom
        assign rom[i] = DATA_W'(i) << (DATA_W - AW);
    end

    // Registered read port
    always_ff @(posedge clk) begin
        data <= rom[addr];
    end

endmodule

// File: rtl/sine_pwm_multi.sv
// Multi-channel sine PWM: one shared LUT, per-channel phase offsets,
// double-buffered config and duty that switch only at a carrier boundary.
// cfg_t is sized from the package widths; keep parameter overrides in step.
module sine_pwm_multi
    import sine_pwm_pkg::*;
#(
    parameter int N_CH           = N_CH_DEF,
    parameter int CNT_W          = CNT_W_DEF,
    parameter int AW             = AW_DEF,
    parameter int DATA_W         = DATA_W_DEF,
    parameter int PERIOD_DEFAULT = RST_PERIOD,
    parameter int MIN_PERIOD     = N_CH + 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 cfg_load,
    input  logic [CNT_W-1:0]     cfg_period,
    input  logic [AW-1:0]        cfg_phase_inc,
    input  logic [7:0]           cfg_amp,
    input  logic [N_CH*AW-1:0]   cfg_phase_off,
    output logic [N_CH-1:0]      pwm_out,
    output logic                 sync
);

    localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    localparam cfg_t CFG_RST = '{
        period:    CNT_W'(PERIOD_DEFAULT),
        phase_inc: RST_PHASE_INC,
        amp:       RST_AMP,
        phase_off: '0
    };

    cfg_t                        cfg_in, cfg_act, cfg_pend, cfg_use;
    logic                        pend;
    logic [CNT_W-1:0]            cnt;
    logic                        start, issue;
    logic [IDX_W-1:0]            ch;
    state_t                      state;
    logic [AW-1:0]               phase_acc;
    logic [2:0]                  vld_pipe;
    logic [2:0][IDX_W-1:0]       ch_pipe;
    logic [AW-1:0]               addr_q;
    logic [DATA_W-1:0]           sample, v_q, v_next;
    logic signed [DATA_W:0]      c;
    logic signed [SCL_W-1:0]     cs;
    logic [CNT_W:0]              period_p1;
    logic [PROD_W-1:0]           dprod;
    logic                        unused_prod;
    logic [N_CH-1:0][CNT_W-1:0]  duty_act, duty_shadow;

    // Period values below the pipeline depth are clamped on capture
    assign cfg_in = '{
        period:    (cfg_period < CNT_W'(MIN_PERIOD)) ? CNT_W'(MIN_PERIOD) : cfg_period,
        phase_inc: cfg_phase_inc,
        amp:       cfg_amp,
        phase_off: cfg_phase_off
    };

    assign start = en && (cnt == '0);
    assign issue = en && (cnt < CNT_W'(N_CH));
    assign ch    = cnt[IDX_W-1:0];

    // The channel-0 issue shares its cycle with the config swap, so it must
    // already see the config that becomes active on this edge.
    assign cfg_use = (start && pend) ? cfg_pend : cfg_act;

    // Amplitude scale around midscale, then scale to the carrier period
    assign c         = $signed({1'b0, sample}) - $signed({1'b0, MIDSCALE});
    assign cs        = SCL_W'(c) * SCL_W'($signed({1'b0, cfg_act.amp}));
    assign v_next    = DATA_W'(cs >>> 8) + MIDSCALE;
    assign period_p1 = {1'b0, cfg_act.period} + (CNT_W+1)'(1);
    assign dprod     = PROD_W'(v_q) * PROD_W'(period_p1);
    assign unused_prod = ^{dprod[PROD_W-1], dprod[DATA_W-1:0]};

    sine_lut #(.AW(AW), .DATA_W(DATA_W)) u_lut (
        .clk  (clk),
        .addr (addr_q),
        .data (sample)
    );

    // Carrier counter: 0..period while enabled, parked at 0 otherwise
    always_ff @(posedge clk) begin
        if (rst || !en)                  cnt <= '0;
        else if (cnt == cfg_act.period)  cnt <= '0;
        else                             cnt <= cnt + CNT_W'(1);
    end

    // Config double buffer: capture any time, promote at period start
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_act  <= CFG_RST;
            cfg_pend <= CFG_RST;
            pend     <= 1'b0;
        end else begin
            if (start && pend) cfg_act <= cfg_pend;
            if (cfg_load) begin
                cfg_pend <= cfg_in;
                pend     <= 1'b1;
            end else if (start) begin
                pend     <= 1'b0;
            end
        end
    end

    // Sequencer: issue slots, then one drain cycle that advances the phase
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            phase_acc <= '0;
        end else if (!en) begin
            state     <= S_IDLE;
        end else begin
            if (state == S_DRAIN) phase_acc <= phase_acc + cfg_act.phase_inc;
            if (cnt < CNT_W'(N_CH - 1))       state <= S_ISSUE;
            else if (cnt == CNT_W'(N_CH - 1)) state <= S_DRAIN;
            else                              state <= S_WAIT_WRAP;
        end
    end

    // Duty pipeline: address register -> LUT -> amplitude -> period
    always_ff @(posedge clk) begin
        if (rst || !en) vld_pipe <= '0;
        else            vld_pipe <= {vld_pipe[1:0], issue};
        addr_q  <= phase_acc + cfg_use.phase_off[ch];
        ch_pipe <= {ch_pipe[1:0], ch};
        v_q     <= v_next;
    end

    // Duty buffers and registered comparators
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            duty_act    <= '0;
            duty_shadow <= '0;
            pwm_out     <= '0;
            sync        <= 1'b0;
        end else begin
            sync <= start;
            for (int k = 0; k < N_CH; k++) pwm_out[k] <= (cnt < duty_act[k]);
            if (start)       duty_act <= duty_shadow;
            if (vld_pipe[2]) duty_shadow[ch_pipe[2]] <= dprod[DATA_W +: CNT_W];
        end
    end

endmodule
